// File: rtl/timer_ctrl_if.sv
// Register bus between the CPU side and the timer controller.
// The master drives the write strobe, address and write data; the slave
// returns read data and the interrupt request.
interface timer_ctrl_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             we;
   logic [1:0]       addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic             irq;

   modport master (
      output we, addr, wdata,
      input  rdata, irq
   );

   modport slave (
      input  we, addr, wdata,
      output rdata, irq
   );
endinterface

// File: rtl/timer_ctrl.sv
// Down-counting timer controller with a CPU register bus.
// Registers: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET (r/w), 2 COUNT (ro), 3 reserved.
// Sequence: IDLE -> LOAD -> CNT ... -> INT. At terminal count the pending flag
// is set. In one-shot mode hardware clears EN. In auto-reload mode EN stays set
// and the next run starts.
module timer_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input logic          clock,
   input logic          reset_n,
   timer_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CNT  = 2'd2;
   localparam logic [1:0] ST_INT  = 2'd3;

   localparam logic [1:0] MODE_RELOAD = 2'b01;

   logic [1:0]       state;
   logic             ctrl_en;
   logic [1:0]       ctrl_mode;
   logic             ctrl_im;
   logic [WIDTH-1:0] preset_q;
   logic [WIDTH-1:0] count_q;
   logic             pend;

   logic             wr_ctrl;
   logic             wr_preset;
   logic             reload;
   logic             terminal;

   assign wr_ctrl   = bus.we && (bus.addr == 2'd0);
   assign wr_preset = bus.we && (bus.addr == 2'd1);
   // MODE values 10 and 11 fall back to one-shot.
   assign reload    = (ctrl_mode == MODE_RELOAD);
   // A preset of 0 is treated like 1: the first CNT cycle is already terminal.
   assign terminal  = (state == ST_CNT) && ctrl_en && (count_q <= WIDTH'(1));

   // CTRL register. A software write in the same cycle as the one-shot EN clear takes priority.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 2'b00;
         ctrl_im   <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en   <= bus.wdata[0];
         ctrl_mode <= bus.wdata[2:1];
         ctrl_im   <= bus.wdata[3];
      end else if ((state == ST_INT) && !reload) begin
         ctrl_en   <= 1'b0;
      end
   end

   // PRESET register. A running count only picks up a new value at the next LOAD.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         preset_q <= '0;
      end else if (wr_preset) begin
         preset_q <= bus.wdata;
      end
   end

   // Pending flag. Terminal count takes priority over a CTRL-write clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend <= 1'b0;
      end else if (terminal) begin
         pend <= 1'b1;
      end else if (wr_ctrl) begin
         pend <= 1'b0;
      end
   end

   // Sequencer and counter. One state transition per clock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         count_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ctrl_en) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (ctrl_en) begin
                  count_q <= preset_q;
                  state   <= ST_CNT;
               end else begin
                  state   <= ST_IDLE;
               end
            end
            ST_CNT: begin
               if (!ctrl_en) begin
                  state <= ST_IDLE;
               end else if (count_q > WIDTH'(1)) begin
                  count_q <= count_q - WIDTH'(1);
               end else begin
                  count_q <= '0;
                  state   <= ST_INT;
               end
            end
            ST_INT: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Combinational register read of the addressed register.
   always_comb begin
      bus.rdata = '0;
      case (bus.addr)
         2'd0:    bus.rdata[3:0] = {ctrl_im, ctrl_mode, ctrl_en};
         2'd1:    bus.rdata = preset_q;
         2'd2:    bus.rdata = count_q;
         default: bus.rdata = '0;
      endcase
   end

   assign bus.irq = pend & ctrl_im;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl. Expected values are worked out by hand
// from the edge at which CTRL.EN is written (edge t).
module tb_timer_ctrl;

   logic clock;
   logic reset_n;
   int   nchecks;
   int   nerrs;

   timer_ctrl_if #(.WIDTH(32)) bus ();

   timer_ctrl #(.WIDTH(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Register write taking effect at the next rising edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.we    = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clock);
      #1;
      bus.we    = 1'b0;
      bus.wdata = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus.addr = a;
      #1;
      check(tag, bus.rdata, exp);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      nchecks   = 0;
      nerrs     = 0;
      reset_n   = 1'b0;
      bus.we    = 1'b0;
      bus.addr  = 2'd0;
      bus.wdata = '0;

      // Reset values on every address.
      rd_chk("rst_ctrl",   2'd0, 32'h0);
      rd_chk("rst_preset", 2'd1, 32'h0);
      rd_chk("rst_count",  2'd2, 32'h0);
      rd_chk("rst_rsvd",   2'd3, 32'h0);
      check("rst_irq", {31'h0, bus.irq}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      tick(1);

      // Register access: PRESET r/w, COUNT and reserved ignore writes, CTRL masks bits.
      wr(2'd1, 32'hA5A5_0001);
      rd_chk("preset_rw", 2'd1, 32'hA5A5_0001);
      wr(2'd2, 32'h0000_1234);
      rd_chk("count_ro", 2'd2, 32'h0);
      wr(2'd3, 32'h0000_00FF);
      rd_chk("rsvd_ro", 2'd3, 32'h0);
      wr(2'd0, 32'hFFFF_FFF6);
      rd_chk("ctrl_mask", 2'd0, 32'h6);
      tick(2);
      rd_chk("ctrl_noen_count", 2'd2, 32'h0);
      wr(2'd0, 32'h0);

      // One-shot, PRESET=5, IM set.
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);                 // edge t
      tick(2);                         // t+2
      for (int k = 0; k < 5; k++) begin
         rd_chk("os_count", 2'd2, 32'(5 - k));
         check("os_irq_low", {31'h0, bus.irq}, 32'h0);
         tick(1);
      end
      rd_chk("os_count_zero", 2'd2, 32'h0);   // t+7
      check("os_irq_high", {31'h0, bus.irq}, 32'h1);
      tick(1);                                // t+8
      rd_chk("os_en_cleared", 2'd0, 32'h8);
      tick(3);
      check("os_irq_held", {31'h0, bus.irq}, 32'h1);
      rd_chk("os_count_held", 2'd2, 32'h0);
      wr(2'd0, 32'h0);
      check("os_irq_cleared", {31'h0, bus.irq}, 32'h0);

      // Auto-reload, PRESET=3: terminal every 6 cycles, then freeze by clearing EN.
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);                 // edge t
      tick(2);
      rd_chk("ar_c3", 2'd2, 32'd3);    // t+2
      tick(1);
      rd_chk("ar_c2", 2'd2, 32'd2);
      tick(1);
      rd_chk("ar_c1", 2'd2, 32'd1);
      tick(1);                         // t+5
      rd_chk("ar_c0", 2'd2, 32'd0);
      check("ar_irq1", {31'h0, bus.irq}, 32'h1);
      wr(2'd0, 32'hB);                 // t+6, clears pend
      check("ar_irq_clr", {31'h0, bus.irq}, 32'h0);
      tick(1);                         // t+7 LOAD
      rd_chk("ar_load_hold", 2'd2, 32'd0);
      tick(1);                         // t+8
      rd_chk("ar_reload", 2'd2, 32'd3);
      tick(2);                         // t+10
      check("ar_irq_before", {31'h0, bus.irq}, 32'h0);
      tick(1);                         // t+11
      check("ar_irq2", {31'h0, bus.irq}, 32'h1);
      wr(2'd0, 32'hB);                 // t+12
      tick(2);                         // t+14
      rd_chk("ar_c3_b", 2'd2, 32'd3);
      wr(2'd0, 32'hA);                 // t+15, EN cleared
      rd_chk("ar_c2_b", 2'd2, 32'd2);
      tick(4);
      rd_chk("ar_frozen", 2'd2, 32'd2);
      check("ar_frozen_irq", {31'h0, bus.irq}, 32'h0);
      rd_chk("ar_frozen_ctrl", 2'd0, 32'hA);

      // IM=0, PRESET=4: pend rises but irq stays low.
      wr(2'd1, 32'd4);
      wr(2'd0, 32'h1);                 // edge t
      tick(5);                         // t+5
      rd_chk("nim_c1", 2'd2, 32'd1);
      check("nim_pend_low", {31'h0, dut.pend}, 32'h0);
      tick(1);                         // t+6
      rd_chk("nim_c0", 2'd2, 32'd0);
      check("nim_pend_high", {31'h0, dut.pend}, 32'h1);
      check("nim_irq_low", {31'h0, bus.irq}, 32'h0);
      tick(1);
      rd_chk("nim_ctrl", 2'd0, 32'h0);
      wr(2'd0, 32'h8);
      check("nim_pend_clr", {31'h0, dut.pend}, 32'h0);
      check("nim_irq_after", {31'h0, bus.irq}, 32'h0);

      // PRESET=0 with MODE=10 (one-shot fallback): INT two cycles after LOAD.
      wr(2'd1, 32'd0);
      wr(2'd0, 32'hD);                 // edge t
      tick(1);
      check("p0_load", 32'(dut.state), 32'd1);
      tick(1);
      check("p0_cnt", 32'(dut.state), 32'd2);
      check("p0_irq_low", {31'h0, bus.irq}, 32'h0);
      tick(1);
      check("p0_int", 32'(dut.state), 32'd3);
      check("p0_irq_high", {31'h0, bus.irq}, 32'h1);
      rd_chk("p0_count", 2'd2, 32'd0);
      tick(1);
      rd_chk("p0_mode10_oneshot", 2'd0, 32'hC);
      wr(2'd0, 32'h0);

      // PRESET rewritten during CNT: current run unaffected, next reload uses it.
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);                 // edge t
      tick(2);
      rd_chk("pr_c3", 2'd2, 32'd3);
      wr(2'd1, 32'd10);                // t+3
      rd_chk("pr_c2", 2'd2, 32'd2);
      tick(2);                         // t+5
      rd_chk("pr_c0", 2'd2, 32'd0);
      check("pr_irq", {31'h0, bus.irq}, 32'h1);
      tick(3);                         // t+8
      rd_chk("pr_c10", 2'd2, 32'd10);
      tick(3);                         // t+11
      rd_chk("pr_c7", 2'd2, 32'd7);

      // Asynchronous reset mid-count.
      reset_n = 1'b0;
      #1;
      check("ar_rst_state", 32'(dut.state), 32'd0);
      check("ar_rst_irq", {31'h0, bus.irq}, 32'h0);
      rd_chk("ar_rst_count", 2'd2, 32'd0);
      rd_chk("ar_rst_ctrl", 2'd0, 32'd0);
      rd_chk("ar_rst_preset", 2'd1, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      tick(3);
      check("post_rst_state", 32'(dut.state), 32'd0);
      rd_chk("post_rst_count", 2'd2, 32'd0);
      check("post_rst_irq", {31'h0, bus.irq}, 32'h0);

      $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
      $finish;
   end

endmodule
